// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: memory request/response, decoder handshake, next-PC update.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        busy;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault, busy,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, out_ready,
           upd_valid, upd_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_fault, busy,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, out_ready,
           upd_valid, upd_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one fetch in flight, waits for the executed next-PC before refetching.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  ifu_fetch_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  localparam logic [1:0] REQ      = 2'd0;
  localparam logic [1:0] WAIT_RSP = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] WAIT_PC  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      opc_q, opc_d;
  logic             fault_q, fault_d;
  logic             req_valid_q, req_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_inst       = inst_q;
  assign bus.out_pc         = opc_q;
  assign bus.out_fault      = fault_q;
  assign bus.busy           = busy_q;

  // State and output registers; reset lands in REQ with the request raised on the first edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      inst_q      <= '0;
      opc_q       <= '0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      opc_q       <= opc_d;
      fault_q     <= fault_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; handshake flags are decoded from the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    fault_d = fault_q;

    case (state_q)
      REQ: begin
        if (req_valid_q && bus.imem_req_ready) begin
          state_d = WAIT_RSP;
          cnt_d   = '0;
        end
      end
      WAIT_RSP: begin
        if (bus.imem_rsp_valid) begin
          inst_d  = bus.imem_rsp_err ? NOP : bus.imem_rsp_data;
          opc_d   = pc_q;
          fault_d = bus.imem_rsp_err;
          state_d = HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          inst_d  = NOP;
          opc_d   = pc_q;
          fault_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (bus.upd_valid) begin
          pc_d = bus.upd_pc;
          if (bus.upd_pc[1:0] != 2'b00) begin
            // Misaligned target: fault straight to the decoder without touching the bus.
            inst_d  = NOP;
            opc_d   = bus.upd_pc;
            fault_d = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = REQ;
    endcase

    req_valid_d = (state_d == REQ);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != WAIT_PC);
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the single-cycle decode/execute core.
- Owns the PC and issues one 32-bit fetch per instruction over a valid/ready memory interface.
- Presents the fetched instruction to the decoder through an output valid/ready handshake.
- Waits for the executed next-PC before fetching again: strictly one instruction in flight, no speculation.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles spent in WAIT_RSP before a bus-timeout fault is flagged; 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address; equals pc.
- imem_rsp_valid  in  1  response data valid (single-cycle pulse).
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_err  in  1  access error; qualified by imem_rsp_valid.
- out_valid  out  1  instruction held for the decoder.
- out_ready  in  1  decoder consumes the instruction.
- out_inst  out  32  instruction word.
- out_pc  out  32  PC of out_inst.
- out_fault  out  1  fetch fault; out_inst is 32'h00000013 (nop) when set.
- upd_valid  in  1  next PC from execute is valid.
- upd_pc  in  32  next PC (jal/jalr target or pc+4).
- busy  out  1  high in every state except WAIT_PC.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-transaction:
  - state=REQ, pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_fault=0, timeout counter=0.
  - imem_req_valid becomes 1 in the first cycle after reset deasserts.
  - A response that arrives after a mid-operation reset is ignored, because the FSM is in REQ.
- REQ state:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid & imem_req_ready -> WAIT_RSP, counter cleared.
  - The address must stay stable while waiting for ready.
- WAIT_RSP state:
  - imem_req_valid=0; the counter increments each cycle.
  - On imem_rsp_valid: latch out_inst=imem_rsp_data, out_pc=pc, out_fault=imem_rsp_err -> HOLD.
  - If imem_rsp_err=1, out_inst=32'h00000013 instead of the returned data.
  - If the counter reaches TIMEOUT with no response: out_fault=1, out_inst=32'h00000013 -> HOLD.
  - A later stray response is ignored.
- HOLD state:
  - out_valid=1; out_inst, out_pc and out_fault are stable until accepted.
  - On out_ready -> WAIT_PC, out_valid=0 on the next cycle.
- WAIT_PC state:
  - On upd_valid: pc<=upd_pc -> REQ.
  - upd_valid in any other state is ignored (no queueing).
- Alignment:
  - If upd_pc[1:0]!=0, pc is still updated, but no bus request is made.
  - The FSM goes directly to HOLD with out_fault=1, out_inst=nop, out_pc=upd_pc.
- Latency:
  - Minimum from upd_valid to out_valid is 3 cycles, with ready=1 and a response on the cycle after acceptance.
  - Throughput is at most one instruction per 4 cycles.
- Widths: pc and upd_pc are full 32-bit, with no wrap checks. pc=32'hFFFFFFFC is legal and is fetched as-is.
- out_ready while out_valid=0 has no effect.
- imem_rsp_valid outside WAIT_RSP has no effect.

Test Plan:
- Reset release:
  - Response 32'h00000297 one cycle after acceptance -> imem_req_addr=32'h80000000.
  - out_valid=1 with out_inst=32'h00000297, out_pc=32'h80000000, out_fault=0.
- Back-pressure:
  - imem_req_ready low 5 cycles -> req_valid held, addr stable.
  - out_ready low 4 cycles -> out_* stable, no new request.
  - Then upd_pc=32'h80000004 -> next req_addr=32'h80000004.
- Jump:
  - upd_pc=32'h80000100 -> fetch of 0x80000100.
  - upd_valid asserted during HOLD is ignored: pc unchanged, no request.
- Error and timeout:
  - rsp_err=1 -> out_fault=1, out_inst=32'h00000013.
  - No response for 255 cycles -> fault.
  - A late response at cycle 300 is ignored.
- Misaligned:
  - upd_pc=32'h80000002 -> no imem_req_valid.
  - out_valid next cycle with out_fault=1, out_pc=32'h80000002.
- Async reset mid-WAIT_RSP:
  - out_valid=0 immediately.
  - The stale response is dropped.
  - The next request goes to 32'h80000000.
